serial_word_collector: RTL and testbench

//   Downstream stage of buf_cnt: consumes its serial output (SO) and carry-out (co).

---
 rtl/serial_word_collector.sv | 135 +++++++++++++
 tb/tb_serial_word_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector - MSB-first serial-to-word collector with framing check and 2-entry output buffer
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             si_vld,
    input  logic             si_last,
    output logic [WIDTH-1:0] PO,
    output logic             po_vld,
    input  logic             po_rdy,
    output logic             busy,
    output logic             frame_err,
    output logic             ovf,
    output logic             ovf_stky
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    buf_state_e       state_q, state_d;
    // Only WIDTH-1 bits need storing: the final bit is taken straight from SI.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             ovf_q, ovf_d;
    logic             ovf_stky_q, ovf_stky_d;

    logic             last_pos;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] word;

    assign last_pos = (bit_cnt_q == CW'(WIDTH - 1));
    assign push     = si_vld & last_pos;
    assign word     = {shreg_q, SI};
    assign pop      = (state_q != EMPTY) & po_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_stky_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            ovf_stky_q  <= ovf_stky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = FULL;
                     else if (pop && !push) state_d = EMPTY;
            FULL:    if (pop && !push) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        drop        = 1'b0;
        frame_err_d = 1'b0;

        // An early si_last aborts the partial word; a missing one still delivers it.
        if (si_vld) begin
            frame_err_d = si_last ^ last_pos;
            if (si_last && !last_pos) begin
                shreg_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shreg_d   = word[WIDTH-2:0];
                bit_cnt_d = last_pos ? '0 : bit_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            EMPTY: if (push) head_d = word;
            ONE: begin
                if (push && pop)  head_d = word;
                else if (push)    tail_d = word;
                else if (pop)     head_d = '0;
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = word;
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: head_d = '0;
        endcase

        busy_d     = (bit_cnt_d != '0);
        ovf_d      = drop;
        ovf_stky_d = ovf_stky_q | drop;
    end

    always_comb begin
        po_vld    = (state_q != EMPTY);
        PO        = head_q;
        busy      = busy_q;
        frame_err = frame_err_q;
        ovf       = ovf_q;
        ovf_stky  = ovf_stky_q;
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - randomized scoreboard bench for serial_word_collector
module tb_serial_word_collector;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         SI = 1'b0;
    logic         si_vld = 1'b0;
    logic         si_last = 1'b0;
    logic         po_rdy = 1'b0;
    logic [W-1:0] PO;
    logic         po_vld;
    logic         busy;
    logic         frame_err;
    logic         ovf;
    logic         ovf_stky;

    serial_word_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .SI        (SI),
        .si_vld    (si_vld),
        .si_last   (si_last),
        .PO        (PO),
        .po_vld    (po_vld),
        .po_rdy    (po_rdy),
        .busy      (busy),
        .frame_err (frame_err),
        .ovf       (ovf),
        .ovf_stky  (ovf_stky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] head;
        logic         busy;
        logic         ferr;
        logic         ovf;
        logic         stky;
    } exp_t;

    // Reference model: bits of the frame in progress, buffered words, accepted words.
    bit           bitq[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] acc[$];
    exp_t         fq[$];
    logic         m_stky = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flush_model();
        bitq.delete();
        mq.delete();
        acc.delete();
        fq.delete();
        m_stky = 1'b0;
    endtask

    task automatic drive(input logic v, input logic b, input logic l, input logic r);
        logic         ferr;
        logic         drop;
        logic         push;
        logic [W-1:0] w;
        exp_t         e;
        @(posedge clk);
        #1;
        si_vld = v; SI = b; si_last = l; po_rdy = r;
        ferr = 1'b0; drop = 1'b0; push = 1'b0; w = '0;
        if (mq.size() > 0 && r) acc.push_back(mq.pop_front());
        if (v) begin
            bitq.push_back(b);
            if (bitq.size() == W) begin
                foreach (bitq[i]) w = {w[W-2:0], bitq[i]};
                ferr = !l;
                push = 1'b1;
                bitq.delete();
            end else if (l) begin
                ferr = 1'b1;
                bitq.delete();
            end
        end
        if (push) begin
            if (mq.size() < 2) mq.push_back(w);
            else drop = 1'b1;
        end
        m_stky = m_stky | drop;
        e.vld  = (mq.size() > 0);
        e.head = (mq.size() > 0) ? mq[0] : '0;
        e.busy = (bitq.size() != 0);
        e.ferr = ferr;
        e.ovf  = drop;
        e.stky = m_stky;
        fq.push_back(e);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int last_at,
                             input bit toggle, input logic r);
        for (int i = 0; i < n; i++) begin
            if (toggle) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
            drive(1'b1, w[n-1-i], (i == last_at), r);
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, r);
    endtask

    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] w;
        if (rst) begin
            if (po_vld && po_rdy) begin
                if (acc.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    w = acc.pop_front();
                    chk("accepted_word", int'(PO), int'(w));
                end
            end
            if (fq.size() >= 2) begin
                e = fq.pop_front();
                chk("po_vld", int'(po_vld), int'(e.vld));
                chk("PO", int'(PO), int'(e.head));
                chk("busy", int'(busy), int'(e.busy));
                chk("frame_err", int'(frame_err), int'(e.ferr));
                chk("ovf", int'(ovf), int'(e.ovf));
                chk("ovf_stky", int'(ovf_stky), int'(e.stky));
            end
        end
    end

    initial begin
        int sz;
        logic l;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_PO", int'(PO), 0);
        chk("rst_po_vld", int'(po_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ovf_stky", int'(ovf_stky), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        send_bits(8'h0A, 8, 7, 1'b0, 1'b1);
        idle(3, 1'b1);

        send_bits(8'hA5, 8, 7, 1'b0, 1'b0);
        send_bits(8'h3C, 8, 7, 1'b0, 1'b0);
        send_bits(8'hFF, 8, 7, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        send_bits(8'h16, 5, 4, 1'b0, 1'b1);
        send_bits(8'h81, 8, 7, 1'b0, 1'b1);
        idle(2, 1'b1);

        send_bits(8'hC3, 8, -1, 1'b0, 1'b1);
        idle(2, 1'b1);

        send_bits(8'h5A, 8, 7, 1'b1, 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            sz = bitq.size();
            l = (sz == W - 1) ^ ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), l,
                  1'($urandom_range(0, 1)));
        end
        idle(4, 1'b1);

        send_bits(8'h3C, 8, 7, 1'b0, 1'b0);
        send_bits(8'h0D, 4, -1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_po_vld", int'(po_vld), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ovf_stky", int'(ovf_stky), 0);
        chk("async_PO", int'(PO), 0);
        flush_model();
        si_vld = 1'b0; si_last = 1'b0; po_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_bits(8'h0A, 8, 7, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        chk("all_words_delivered", acc.size() + mq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
